mix_columns_iter: RTL and testbench

Parametrised, iterative AES MixColumns / InvMixColumns engine with a valid/ready handshake on both sides. It accepts one DATA_LEN-bit state per transaction and processes COLS_PER_CYCLE 32-bit columns per clock over several cycles. The result is held until the downstream stage takes it. It sits between ShiftRows and AddRoundKey in the round datapath. It also replaces the fixed single-cycle MixColumns where area matters or where the decrypt path needs the inverse transform.

---
 rtl/mix_columns_iter.sv | 179 +++++++++++++++++
 tb/tb_mix_columns_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns / InvMixColumns engine.
// One state is accepted per transaction. COLS_PER_CYCLE columns are
// transformed in place on each clock. The finished state is held on
// data_out until the downstream stage takes it.
// Optional macro MIXCOL_INV_EN: builds the InvMixColumns matrix and honours inv.
// When it is undefined, every transaction uses forward MixColumns.
`timescale 1ns/1ps
module mix_columns_iter #(
  parameter int DATA_LEN       = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic                inv,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [DATA_LEN-1:0] data_out
);

  localparam int NUM_COLS = DATA_LEN / 32;
  localparam int ITER     = NUM_COLS / COLS_PER_CYCLE;
  localparam int CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic                            ready_q;
  // Column c of the state lives at packed index NUM_COLS-1-c (row 0 = MSB).
  logic [NUM_COLS-1:0][31:0]       work;
  logic [NUM_COLS-1:0][31:0]       work_nx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_sel;
  logic [COLS_PER_CYCLE-1:0][31:0] col_mix;

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column transform, circulant (02 03 01 01).
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] t0, t1, t2, t3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    t0 = xtime(a0);
    t1 = xtime(a1);
    t2 = xtime(a2);
    t3 = xtime(a3);
    return {t0 ^ t1 ^ a1 ^ a2 ^ a3,
            a0 ^ t1 ^ t2 ^ a2 ^ a3,
            a0 ^ a1 ^ t2 ^ t3 ^ a3,
            t0 ^ a0 ^ a1 ^ a2 ^ t3};
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q;

  // Inverse column transform, circulant (0E 0B 0D 09), built from x2/x4/x8.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`else
  // The mode input has no effect when the inverse matrix is not built.
  logic unused_inv;
  assign unused_inv = inv;
`endif

  // The block only advertises space once out of reset and back in IDLE.
  assign ready_in = ready_q & reset;

  // Pick the COLS_PER_CYCLE columns of the current group.
  always_comb begin
    col_sel = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int g = 0; g < ITER; g++) begin
        if (cnt == CNT_W'(g)) col_sel[k] = work[NUM_COLS-1-(g*COLS_PER_CYCLE+k)];
      end
    end
  end

  // Transform the selected columns in the mode latched at accept.
  always_comb begin
    col_mix = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIXCOL_INV_EN
      col_mix[k] = inv_q ? mix_inv(col_sel[k]) : mix_fwd(col_sel[k]);
`else
      col_mix[k] = mix_fwd(col_sel[k]);
`endif
    end
  end

  // Write the transformed group back into its slot of the working state.
  always_comb begin
    work_nx = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int g = 0; g < ITER; g++) begin
        if (cnt == CNT_W'(g)) work_nx[NUM_COLS-1-(g*COLS_PER_CYCLE+k)] = col_mix[k];
      end
    end
  end

  // Handshake FSM; data_out is loaded only on the final BUSY edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ready_q   <= 1'b1;
`ifdef MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_q) begin
            work    <= data_in;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= BUSY;
`ifdef MIXCOL_INV_EN
            inv_q   <= inv;
`endif
          end
        end
        BUSY: begin
          work <= work_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            data_out  <= work_nx;
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter: one instance with 1 column per cycle,
// one with 4 columns per cycle, sharing clock and reset.
`timescale 1ns/1ps
module tb_mix_columns_iter;

  logic         clk;
  logic         reset;

  logic         a_valid_in, a_ready_in, a_inv, a_valid_out, a_ready_out;
  logic [127:0] a_data_in, a_data_out;
  logic         b_valid_in, b_ready_in, b_inv, b_valid_out, b_ready_out;
  logic [127:0] b_data_in, b_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] KAT1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] KAT1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] KAT2_IN  = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
  localparam logic [127:0] KAT2_OUT = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;
  localparam logic [127:0] ORD_IN   = 128'h01010101c6c6c6c6db135345f20a225c;
  localparam logic [127:0] ORD_OUT  = 128'h01010101c6c6c6c68e4da1bc9fdc589d;

  mix_columns_iter #(.DATA_LEN(128), .COLS_PER_CYCLE(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (a_valid_in),
    .ready_in  (a_ready_in),
    .inv       (a_inv),
    .data_in   (a_data_in),
    .valid_out (a_valid_out),
    .ready_out (a_ready_out),
    .data_out  (a_data_out)
  );

  mix_columns_iter #(.DATA_LEN(128), .COLS_PER_CYCLE(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (b_valid_in),
    .ready_in  (b_ready_in),
    .inv       (b_inv),
    .data_in   (b_data_in),
    .valid_out (b_valid_out),
    .ready_out (b_ready_out),
    .data_out  (b_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send one state to dut_a, scramble inputs while busy, measure latency.
  task automatic run_a(input string tag, input logic [127:0] din, input logic iv,
                       input logic [127:0] exp, input int exp_lat);
    int lat;
    logic [127:0] prev;
    prev = a_data_out;
    lat  = 0;
    while (!a_ready_in && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    a_valid_in = 1'b1;
    a_data_in  = din;
    a_inv      = iv;
    @(posedge clk); #1;
    a_valid_in = 1'b0;
    a_data_in  = ~din;
    a_inv      = ~iv;
    lat = 0;
    while (!a_valid_out && lat < 20) begin
      chk128({tag, "_hold"}, a_data_out, prev);
      @(posedge clk); #1;
      lat++;
    end
    chk_int({tag, "_lat"}, lat, exp_lat);
    chk128({tag, "_data"}, a_data_out, exp);
  endtask

  // Let dut_a hand off its result and confirm it returns to IDLE.
  task automatic take_a(input string tag);
    a_ready_out = 1'b1;
    @(posedge clk); #1;
    a_ready_out = 1'b0;
    chk1({tag, "_vo_fall"}, a_valid_out, 1'b0);
    chk1({tag, "_rdy_back"}, a_ready_in, 1'b1);
  endtask

  task automatic run_b(input string tag, input logic [127:0] din,
                       input logic [127:0] exp, input int exp_lat);
    int lat;
    b_valid_in = 1'b1;
    b_data_in  = din;
    b_inv      = 1'b0;
    @(posedge clk); #1;
    b_valid_in = 1'b0;
    b_data_in  = ~din;
    lat = 0;
    while (!b_valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_int({tag, "_lat"}, lat, exp_lat);
    chk128({tag, "_data"}, b_data_out, exp);
    b_ready_out = 1'b1;
    @(posedge clk); #1;
    b_ready_out = 1'b0;
    chk1({tag, "_vo_fall"}, b_valid_out, 1'b0);
    chk1({tag, "_rdy_back"}, b_ready_in, 1'b1);
  endtask

  initial begin
    reset       = 1'b0;
    a_valid_in  = 1'b0;
    a_inv       = 1'b0;
    a_data_in   = '0;
    a_ready_out = 1'b0;
    b_valid_in  = 1'b0;
    b_inv       = 1'b0;
    b_data_in   = '0;
    b_ready_out = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready_a", a_ready_in, 1'b0);
    chk1("rst_valid_a", a_valid_out, 1'b0);
    chk128("rst_data_a", a_data_out, 128'h0);
    chk1("rst_ready_b", b_ready_in, 1'b0);
    chk1("rst_valid_b", b_valid_out, 1'b0);
    reset = 1'b1;
    #1;
    chk1("rel_ready_a", a_ready_in, 1'b1);
    chk1("rel_ready_b", b_ready_in, 1'b1);
    @(posedge clk); #1;
    chk1("idle_valid_a", a_valid_out, 1'b0);

    // Forward known answer, latency 4
    run_a("fwd_kat", KAT1_IN, 1'b0, KAT1_OUT, 4);
    take_a("fwd_kat");

    // Column ordering: transformed columns land in columns 2 and 3
    run_a("col_order", ORD_IN, 1'b0, ORD_OUT, 4);
    take_a("col_order");

    // Mode input: inverse when built, otherwise ignored
`ifdef MIXCOL_INV_EN
    run_a("inv_kat", KAT1_OUT, 1'b1, KAT1_IN, 4);
`else
    run_a("inv_ignored", KAT1_IN, 1'b1, KAT1_OUT, 4);
`endif
    take_a("mode");

    // Backpressure: result held for 10 cycles
    run_a("bp", KAT2_IN, 1'b0, KAT2_OUT, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk1("bp_valid", a_valid_out, 1'b1);
      chk128("bp_data", a_data_out, KAT2_OUT);
      chk1("bp_ready_in", a_ready_in, 1'b0);
    end
    take_a("bp");

    // Reset two cycles into BUSY aborts the transaction
    a_valid_in = 1'b1;
    a_data_in  = KAT1_IN;
    a_inv      = 1'b0;
    @(posedge clk); #1;
    a_valid_in = 1'b0;
    chk1("abort_accepted", a_ready_in, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk1("abort_valid", a_valid_out, 1'b0);
    chk128("abort_data", a_data_out, 128'h0);
    chk1("abort_ready", a_ready_in, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("abort_rel_ready", a_ready_in, 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      chk1("abort_no_result", a_valid_out, 1'b0);
    end
    run_a("post_abort", KAT1_IN, 1'b0, KAT1_OUT, 4);
    take_a("post_abort");

    // Four columns per cycle, latency 1
    run_b("wide_kat2", KAT2_IN, KAT2_OUT, 1);
    run_b("wide_kat1", KAT1_IN, KAT1_OUT, 1);
    run_b("wide_order", ORD_IN, ORD_OUT, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
